// File: rtl/arm_prog_loader_if.sv
// Byte stream carrying the boot image into the loader.
// The source drives valid/data and the loader answers with ready.
interface arm_prog_loader_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/arm_prog_loader.sv
// Boot loader: packs the incoming byte stream into big-endian words, writes the program
// image then the data image, and releases the core reset only after a matching XOR checksum.
module arm_prog_loader #(
  parameter int INS_MEM_SIZE  = 32,
  parameter int DATA_MEM_SIZE = 64,
  parameter int INS_AW        = 5,
  parameter int DATA_AW       = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  arm_prog_loader_if.slave      in_if,
  output logic                  ins_we_o,
  output logic [INS_AW-1:0]     ins_addr_o,
  output logic [31:0]           ins_wdata_o,
  output logic                  data_we_o,
  output logic [DATA_AW-1:0]    data_addr_o,
  output logic [31:0]           data_wdata_o,
  output logic                  cpu_rst_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_INS  = 3'd1,
    S_LOAD_DATA = 3'd2,
    S_CHECK     = 3'd3,
    S_DONE      = 3'd4,
    S_ERR       = 3'd5
  } state_e;

  localparam logic [INS_AW-1:0]  INS_LAST  = INS_AW'(INS_MEM_SIZE - 1);
  localparam logic [DATA_AW-1:0] DATA_LAST = DATA_AW'(DATA_MEM_SIZE - 1);
  localparam logic [INS_AW-1:0]  INS_ONE   = INS_AW'(1);
  localparam logic [DATA_AW-1:0] DATA_ONE  = DATA_AW'(1);

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_e              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         shift_q, shift_d;
  logic [7:0]          csum_q, csum_d;
  logic                ready_q, ready_d;
  logic                ins_we_q, ins_we_d;
  logic [INS_AW-1:0]   ins_addr_q, ins_addr_d;
  logic [31:0]         ins_wdata_q, ins_wdata_d;
  logic                data_we_q, data_we_d;
  logic [DATA_AW-1:0]  data_addr_q, data_addr_d;
  logic [31:0]         data_wdata_q, data_wdata_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                accept_s;
  logic [31:0]         word_s;

  assign accept_s = in_if.valid & ready_q;
  assign word_s   = {shift_q, in_if.data};

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      shift_q      <= 24'd0;
      csum_q       <= 8'd0;
      ready_q      <= 1'b0;
      ins_we_q     <= 1'b0;
      ins_addr_q   <= '0;
      ins_wdata_q  <= 32'd0;
      data_we_q    <= 1'b0;
      data_addr_q  <= '0;
      data_wdata_q <= 32'd0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      csum_q       <= csum_d;
      ready_q      <= ready_d;
      ins_we_q     <= ins_we_d;
      ins_addr_q   <= ins_addr_d;
      ins_wdata_q  <= ins_wdata_d;
      data_we_q    <= data_we_d;
      data_addr_q  <= data_addr_d;
      data_wdata_q <= data_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic: byte packing, write strobes, checksum and status.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    csum_d       = csum_q;
    ins_we_d     = 1'b0;
    ins_wdata_d  = ins_wdata_q;
    data_we_d    = 1'b0;
    data_wdata_d = data_wdata_q;
    cpu_rst_d    = cpu_rst_q;
    done_d       = done_q;
    err_d        = err_q;

    // The address advances after its strobe, but parks on the last index so it never wraps.
    if (ins_we_q && (ins_addr_q != INS_LAST)) begin
      ins_addr_d = ins_addr_q + INS_ONE;
    end else begin
      ins_addr_d = ins_addr_q;
    end
    if (data_we_q && (data_addr_q != DATA_LAST)) begin
      data_addr_d = data_addr_q + DATA_ONE;
    end else begin
      data_addr_d = data_addr_q;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d     = S_LOAD_INS;
          byte_cnt_d  = 2'd0;
          shift_d     = 24'd0;
          csum_d      = 8'd0;
          ins_addr_d  = '0;
          data_addr_d = '0;
          cpu_rst_d   = 1'b1;
          done_d      = 1'b0;
          err_d       = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD_INS: begin
        if (accept_s) begin
          csum_d     = csum_fold(csum_q, in_if.data);
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {shift_q[15:0], in_if.data};
          if (byte_cnt_q == 2'd3) begin
            ins_we_d    = 1'b1;
            ins_wdata_d = word_s;
            if (ins_addr_q == INS_LAST) begin
              state_d = S_LOAD_DATA;
            end else begin
              state_d = S_LOAD_INS;
            end
          end else begin
            ins_we_d = 1'b0;
          end
        end else begin
          state_d = S_LOAD_INS;
        end
      end
      S_LOAD_DATA: begin
        if (accept_s) begin
          csum_d     = csum_fold(csum_q, in_if.data);
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {shift_q[15:0], in_if.data};
          if (byte_cnt_q == 2'd3) begin
            data_we_d    = 1'b1;
            data_wdata_d = word_s;
            if (data_addr_q == DATA_LAST) begin
              state_d = S_CHECK;
            end else begin
              state_d = S_LOAD_DATA;
            end
          end else begin
            data_we_d = 1'b0;
          end
        end else begin
          state_d = S_LOAD_DATA;
        end
      end
      S_CHECK: begin
        if (accept_s) begin
          if (in_if.data == csum_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d   = S_ERR;
            err_d     = 1'b1;
            cpu_rst_d = 1'b1;
          end
        end else begin
          state_d = S_CHECK;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cpu_rst_d = 1'b1;
      end
    endcase

    // ready and busy share one register: both are high exactly in the loading states.
    case (state_d)
      S_LOAD_INS, S_LOAD_DATA, S_CHECK: ready_d = 1'b1;
      default:                          ready_d = 1'b0;
    endcase
  end

  assign in_if.ready  = ready_q;
  assign busy_o       = ready_q;
  assign ins_we_o     = ins_we_q;
  assign ins_addr_o   = ins_addr_q;
  assign ins_wdata_o  = ins_wdata_q;
  assign data_we_o    = data_we_q;
  assign data_addr_o  = data_addr_q;
  assign data_wdata_o = data_wdata_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_arm_prog_loader.sv
// Scoreboard bench for arm_prog_loader: expected word writes are queued as bytes are
// accepted and matched against the write strobes observed on the falling edge.
module tb_arm_prog_loader;
  localparam int INS_N  = 32;
  localparam int DATA_N = 64;
  localparam int WORDS  = INS_N + DATA_N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ins_we, data_we, cpu_rst, busy, done, err;
  logic [4:0]  ins_addr;
  logic [5:0]  data_addr;
  logic [31:0] ins_wdata, data_wdata;

  arm_prog_loader_if in_if();

  arm_prog_loader #(.INS_MEM_SIZE(INS_N), .DATA_MEM_SIZE(DATA_N), .INS_AW(5), .DATA_AW(6)) dut (
    .clk(clk), .rst(rst), .start_i(start), .in_if(in_if),
    .ins_we_o(ins_we), .ins_addr_o(ins_addr), .ins_wdata_o(ins_wdata),
    .data_we_o(data_we), .data_addr_o(data_addr), .data_wdata_o(data_wdata),
    .cpu_rst_o(cpu_rst), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_ins;
    logic [6:0]  addr;
    logic [31:0] wdata;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] image[WORDS];
  int          vec_cnt = 0;
  int          miscmp_cnt = 0;
  int          cyc = 0;
  int          strobe_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Strobe monitor: every write must match the oldest queued word, in the expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (ins_we || data_we) begin
      strobe_cnt++;
      check_eq("we_exclusive", {31'd0, ins_we & data_we}, 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("strobe_kind", {31'd0, ins_we}, {31'd0, e.is_ins});
        check_eq("strobe_cycle", cyc, e.cyc);
        if (e.is_ins) begin
          check_eq("ins_addr", {27'd0, ins_addr}, {25'd0, e.addr});
          check_eq("ins_wdata", ins_wdata, e.wdata);
        end else begin
          check_eq("data_addr", {26'd0, data_addr}, {25'd0, e.addr});
          check_eq("data_wdata", data_wdata, e.wdata);
        end
      end
    end
  end

  function automatic logic [7:0] image_xor();
    logic [7:0] x = 8'd0;
    for (int i = 0; i < WORDS; i++) begin
      x = x ^ image[i][31:24] ^ image[i][23:16] ^ image[i][15:8] ^ image[i][7:0];
    end
    return x;
  endfunction

  function automatic int gap_for(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 3));
    return 0;
  endfunction

  // All tasks enter and leave one time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int  n;
    bit  taken;
    if (gap > 0) begin
      in_if.valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    in_if.valid = 1'b1;
    in_if.data  = b;
    n = 0;
    taken = 1'b0;
    while (!taken) begin
      @(negedge clk);
      taken = in_if.ready;
      @(posedge clk); #1;
      n++;
      if (!taken && n > 50) begin
        check_eq("accept_timeout", 32'd0, 32'd1);
        taken = 1'b1;
      end
    end
  endtask

  task automatic send_word(input int k, input int mode);
    exp_t e;
    logic [31:0] w;
    w = image[k];
    send_byte(w[31:24], gap_for(mode));
    send_byte(w[23:16], gap_for(mode));
    send_byte(w[15:8],  gap_for(mode));
    send_byte(w[7:0],   gap_for(mode));
    e.is_ins = (k < INS_N);
    e.addr   = (k < INS_N) ? 7'(k) : 7'(k - INS_N);
    e.wdata  = w;
    e.cyc    = cyc;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input logic exp_busy);
    in_if.valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("start_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check_eq("start_done", {31'd0, done}, 32'd0);
    check_eq("start_err", {31'd0, err}, 32'd0);
    check_eq("start_busy", {31'd0, busy}, {31'd0, exp_busy});
  endtask

  // One load: nwords words, optional checksum (xor-ed with bad), optional ignored start at word 5.
  task automatic load(input int mode, input int nwords, input bit with_csum,
                      input logic [7:0] bad, input bit mid_start);
    int s0;
    s0 = strobe_cnt;
    pulse_start(1'b1);
    for (int k = 0; k < nwords; k++) begin
      if (mid_start && k == 5) pulse_start(1'b1);
      send_word(k, mode);
    end
    if (with_csum) begin
      check_eq("pre_csum_done", {31'd0, done}, 32'd0);
      check_eq("pre_csum_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      check_eq("pre_csum_busy", {31'd0, busy}, 32'd1);
      send_byte(image_xor() ^ bad, gap_for(mode));
      in_if.valid = 1'b0;
      @(negedge clk);
      check_eq("end_done", {31'd0, done}, {31'd0, (bad == 8'd0)});
      check_eq("end_err", {31'd0, err}, {31'd0, (bad != 8'd0)});
      check_eq("end_cpu_rst", {31'd0, cpu_rst}, {31'd0, (bad != 8'd0)});
      check_eq("end_busy", {31'd0, busy}, 32'd0);
      check_eq("end_ready", {31'd0, in_if.ready}, 32'd0);
      check_eq("strobe_total", strobe_cnt - s0, WORDS);
      check_eq("queue_empty", exp_q.size(), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    in_if.valid = 1'b0;
    in_if.data  = 8'd0;
    image[0] = 32'hE3A01005;
    for (int i = 1; i < WORDS; i++) image[i] = $urandom;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check_eq("rst_ready", {31'd0, in_if.ready}, 32'd0);
    check_eq("rst_ins_we", {31'd0, ins_we}, 32'd0);
    check_eq("rst_data_we", {31'd0, data_we}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_ready", {31'd0, in_if.ready}, 32'd0);

    // Back-to-back full image (first word E3A01005), good checksum
    load(0, WORDS, 1'b1, 8'd0, 1'b0);
    // Corrupted checksum, then a good reload with alternating valid
    load(0, WORDS, 1'b1, 8'h01, 1'b0);
    load(1, WORDS, 1'b1, 8'd0, 1'b0);
    // Random stalls
    load(2, WORDS, 1'b1, 8'd0, 1'b0);

    // Reset after 10 words
    load(2, 10, 1'b0, 8'd0, 1'b0);
    in_if.valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_ready", {31'd0, in_if.ready}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check_eq("midrst_ins_addr", {27'd0, ins_addr}, 32'd0);
    check_eq("midrst_queue", exp_q.size(), 32'd0);
    @(posedge clk); #1;

    // Start pulsed mid-load is ignored; the load finishes normally
    load(2, WORDS, 1'b1, 8'd0, 1'b1);
    // Restart from DONE rewrites from instruction address 0
    load(0, 2, 1'b0, 8'd0, 1'b0);
    in_if.valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_eq("final_queue", exp_q.size(), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
